// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner/decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_t;

    // Per-scan candidate: bit 4 clear means bits [3:0] hold a key code.
    typedef logic [4:0] cand_t;

    localparam cand_t CAND_NONE  = 5'b1_0000;
    localparam cand_t CAND_MULTI = 5'b1_0001;

    // KEYMAP[col][row], row 0 is the top row of the pad.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    function automatic logic cand_is_key(input cand_t c);
        return !c[4];
    endfunction

    // Fold one column sample (pressed bits, active-high) into the running candidate.
    function automatic cand_t cand_merge(input cand_t acc, input logic [3:0] pressed,
                                         input logic [1:0] col_idx);
        int unsigned hits;
        cand_t       hit_key;
        hits    = 0;
        hit_key = CAND_NONE;
        for (int unsigned r = 0; r < 4; r++) begin
            if (pressed[2'(r)]) begin
                hits++;
                hit_key = {1'b0, KEYMAP[col_idx][2'(r)]};
            end
        end
        if (hits == 0)
            return acc;
        if (hits == 1 && acc == CAND_NONE)
            return hit_key;
        return CAND_MULTI;
    endfunction

endpackage

// File: rtl/kypd_col_scanner.sv
// Column walker: holds each column low for SCAN_TICKS cycles and strobes
// the end of every column window and of every full 4-column scan.
module kypd_col_scanner #(
    parameter int unsigned SCAN_TICKS = 16'h4000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    output logic [1:0] col_idx,
    output logic       sample,
    output logic       scan_done
);

    localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

    logic [TW-1:0] tick_cnt;

    // Tick counter wraps at the end of each column window and advances the column.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            col_idx  <= '0;
        end else if (sample) begin
            tick_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Strobes and the one-hot-low column drive.
    always_comb begin
        sample    = (tick_cnt == TICK_LAST);
        scan_done = sample && (col_idx == 2'd3);
        col       = ~(4'b0001 << col_idx);
    end

endmodule

// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad decoder: synchronises the rows, builds one candidate per
// full scan, debounces it over DEBOUNCE_SCANS scans and reports accepted keys.
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS     = 16'h4000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta, row_sync;
    logic [1:0]    col_idx;
    logic          sample, scan_done;
    cand_t         acc_cand, prev_cand, cand_now;
    logic [SW-1:0] stable_cnt, stable_new;
    state_t        state, state_nxt;
    logic          enter_pressed;

    kypd_col_scanner #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_scanner (
        .clk      (clk),
        .rst      (rst),
        .col      (col),
        .col_idx  (col_idx),
        .sample   (sample),
        .scan_done(scan_done)
    );

    // Two-flop synchroniser for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Candidate including the current sample, and the stability count it would produce.
    always_comb begin
        cand_now = cand_merge(acc_cand, ~row_sync, col_idx);
        if (cand_now != prev_cand)
            stable_new = SW'(1);
        else if (stable_cnt >= STABLE_MAX)
            stable_new = stable_cnt;
        else
            stable_new = stable_cnt + SW'(1);
    end

    // Accumulate samples within a scan; commit candidate history at scan end.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cand   <= CAND_NONE;
            prev_cand  <= CAND_NONE;
            stable_cnt <= '0;
        end else if (scan_done) begin
            acc_cand   <= CAND_NONE;
            prev_cand  <= cand_now;
            stable_cnt <= stable_new;
        end else if (sample) begin
            acc_cand   <= cand_now;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic, evaluated only on completed scans.
    always_comb begin
        state_nxt     = state;
        enter_pressed = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (cand_is_key(cand_now))
                        state_nxt = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (!cand_is_key(cand_now) || cand_now != prev_cand) begin
                        state_nxt = IDLE;
                    end else if (stable_new >= STABLE_MAX) begin
                        state_nxt     = PRESSED;
                        enter_pressed = 1'b1;
                    end
                end
                PRESSED: begin
                    if (cand_now == CAND_NONE && stable_new >= STABLE_MAX)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Registered outputs: code latch, one-cycle accept pulse, held flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= enter_pressed;
            key_held  <= (state_nxt == PRESSED);
            if (enter_pressed)
                key_code <= cand_now[3:0];
        end
    end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder with a behavioural keypad and a per-scan reference model.
module tb_keypad_scan_decoder;

    localparam int DEB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;   // bit c*4+r: key at column c, row r is down

    int checks   = 0;
    int failures = 0;
    int cur_code = 0;
    bit cur_held = 1'b0;

    int key_of_pos [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    // reference model state
    int m_state, m_prev, m_stable, m_code;

    typedef struct {
        logic [15:0] mask;
        bit          ev;
        int          ec;
        bit          eh;
    } vec_t;
    vec_t tbl [21];

    keypad_scan_decoder #(
        .SCAN_TICKS    (4),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keys[c*4 + r]) row[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_prev   = -1;
        m_stable = 0;
        m_code   = 0;
    endtask

    // One full scan with a constant key set; cand: -1 none, -2 multi, else code.
    task automatic model_scan(input logic [15:0] mask, output bit ev, output int ec, output bit eh);
        int cand;
        bit same;
        cand = -1;
        if ($countones(mask) > 1) cand = -2;
        else if ($countones(mask) == 1)
            for (int p = 0; p < 16; p++) if (mask[p]) cand = key_of_pos[p];
        same = (cand == m_prev);
        m_stable = same ? ((m_stable < DEB) ? m_stable + 1 : m_stable) : 1;
        ev = 1'b0;
        case (m_state)
            0: if (cand >= 0) m_state = 1;
            1: begin
                if (cand < 0 || !same) m_state = 0;
                else if (m_stable >= DEB) begin
                    m_state = 2;
                    ev      = 1'b1;
                    m_code  = cand;
                end
            end
            default: if (cand == -1 && m_stable >= DEB) m_state = 0;
        endcase
        m_prev = cand;
        ec = m_code;
        eh = (m_state == 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", int'(col), 4'b1110);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        rst      = 1'b0;
        cur_code = 0;
        cur_held = 1'b0;
    endtask

    // Apply a key set for one 16-cycle scan, checking every cycle.
    task automatic run_scan(input logic [15:0] mask, input bit ev, input int ec, input bit eh);
        logic [3:0] exp_col;
        keys = mask;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((i % 16) / 4));
            check("col", int'(col), int'(exp_col));
            if (i < 16) begin
                check("valid_idle", int'(key_valid), 0);
                check("code_hold", int'(key_code), cur_code);
                check("held_hold", int'(key_held), int'(cur_held));
            end else begin
                check("valid_scan", int'(key_valid), int'(ev));
                check("code_scan", int'(key_code), ec);
                check("held_scan", int'(key_held), int'(eh));
            end
        end
        cur_code = ec;
        cur_held = eh;
    endtask

    initial begin
        bit          ev, eh;
        int          ec;
        logic [15:0] mask;
        int          sel, p0, p1;

        tbl[0]  = '{16'h0004, 1'b0, 0, 1'b0};   // key 7 for one scan only
        tbl[1]  = '{16'h0000, 1'b0, 0, 1'b0};
        tbl[2]  = '{16'h0000, 1'b0, 0, 1'b0};
        tbl[3]  = '{16'h0011, 1'b0, 0, 1'b0};   // keys 1+2 chord
        tbl[4]  = '{16'h0011, 1'b0, 0, 1'b0};
        tbl[5]  = '{16'h0011, 1'b0, 0, 1'b0};
        tbl[6]  = '{16'h0011, 1'b0, 0, 1'b0};
        tbl[7]  = '{16'h0000, 1'b0, 0, 1'b0};
        tbl[8]  = '{16'h0020, 1'b0, 0, 1'b0};   // key 5
        tbl[9]  = '{16'h0020, 1'b1, 5, 1'b1};
        tbl[10] = '{16'h0020, 1'b0, 5, 1'b1};
        tbl[11] = '{16'h0000, 1'b0, 5, 1'b1};   // release 5
        tbl[12] = '{16'h0000, 1'b0, 5, 1'b0};
        tbl[13] = '{16'h0000, 1'b0, 5, 1'b0};
        tbl[14] = '{16'h8000, 1'b0, 5, 1'b0};   // key D
        tbl[15] = '{16'h8000, 1'b1, 13, 1'b1};
        tbl[16] = '{16'h8000, 1'b0, 13, 1'b1};
        tbl[17] = '{16'h8010, 1'b0, 13, 1'b1};  // chord while held
        tbl[18] = '{16'h0010, 1'b0, 13, 1'b1};  // other key while held
        tbl[19] = '{16'h0000, 1'b0, 13, 1'b1};
        tbl[20] = '{16'h0000, 1'b0, 13, 1'b0};

        do_reset();
        for (int v = 0; v < 21; v++)
            run_scan(tbl[v].mask, tbl[v].ev, tbl[v].ec, tbl[v].eh);

        // Reset in the middle of debouncing key 9.
        run_scan(16'h0400, 1'b0, 13, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            check("mid_valid", int'(key_valid), 0);
        end
        do_reset();
        run_scan(16'h0400, 1'b0, 0, 1'b0);
        run_scan(16'h0400, 1'b1, 9, 1'b1);
        run_scan(16'h0000, 1'b0, 9, 1'b1);
        run_scan(16'h0000, 1'b0, 9, 1'b0);

        // Randomised key activity against the reference model.
        do_reset();
        model_reset();
        mask = '0;
        for (int s = 0; s < 120; s++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 30) mask = '0;
            else if (sel < 75) mask = mask;
            else if (sel < 92) mask = 16'(1) << $urandom_range(0, 15);
            else begin
                p0 = int'($urandom_range(0, 15));
                p1 = (p0 + int'($urandom_range(1, 15))) % 16;
                mask = (16'(1) << p0) | (16'(1) << p1);
            end
            model_scan(mask, ev, ec, eh);
            run_scan(mask, ev, ec, eh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
